// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - SRAM-like data-cache bus between the MEM stage and the data cache
// The unit side is the master and the cache side is the slave.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [3:0]        data_wstrb;
   logic [31:0]       data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [31:0]       data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving the data-cache bus
// Stalls the pipeline from issue until the bus completes; address errors are flagged before any bus traffic.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        mem_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       rt_data,
   input  logic              flush,
   output logic              stall,
   output logic              done,
   output logic [31:0]       rdata_out,
   output logic              adel,
   output logic              ades,
   mem_access_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateType;

   stateType    state, nextState;
   logic        cancelQ;
   logic        isLoadQ;
   logic [2:0]  typeQ;
   logic [1:0]  offQ;
   logic [31:0] rtQ;

   logic        accessValid, isByte, isHalf, isWord, fault, startReq;
   logic        issue, capture, setCancel;
   logic [1:0]  reqSize;
   logic [ADDR_W-1:0] reqAddr;
   logic [3:0]  reqStrb;
   logic [31:0] reqData;
   logic [4:0]  shUp, shDn, shUpQ, shDnQ;
   logic [31:0] byteWord, halfWord, loadData;

   always_comb begin
      accessValid = (mem_read ^ mem_write) && (mem_type != 3'b110);
      isByte      = (mem_type[1:0] == 2'b00);
      isHalf      = (mem_type[1:0] == 2'b01);
      isWord      = (mem_type == 3'b010);
      fault       = (state == IDLE) && accessValid &&
                    ((isHalf && addr[0]) || (isWord && (addr[1:0] != 2'b00)));
      adel        = fault && mem_read;
      ades        = fault && mem_write;
      startReq    = (state == IDLE) && accessValid && !fault && !flush;
   end

   // Request encoding is computed from the live inputs and registered on issue.
   always_comb begin
      shUp    = {addr[1:0], 3'b000};
      shDn    = {2'd3 - addr[1:0], 3'b000};
      reqSize = 2'd2;
      reqAddr = {addr[ADDR_W-1:2], 2'b00};
      reqStrb = 4'b0000;
      reqData = 32'h0000_0000;
      if (isByte) begin
         reqSize = 2'd0;
         reqAddr = addr;
      end else if (isHalf) begin
         reqSize = 2'd1;
         reqAddr = addr;
      end
      if (mem_write) begin
         case (mem_type)
            3'b000, 3'b100: begin
               reqStrb = 4'b0001 << addr[1:0];
               reqData = {4{rt_data[7:0]}};
            end
            3'b001, 3'b101: begin
               reqStrb = addr[1] ? 4'b1100 : 4'b0011;
               reqData = {2{rt_data[15:0]}};
            end
            3'b011: begin
               reqStrb = 4'b1111 >> (2'd3 - addr[1:0]);
               reqData = rt_data >> shDn;
            end
            3'b111: begin
               reqStrb = 4'b1111 << addr[1:0];
               reqData = rt_data << shUp;
            end
            default: begin
               reqStrb = 4'b1111;
               reqData = rt_data;
            end
         endcase
      end
   end

   always_comb begin
      shUpQ    = {offQ, 3'b000};
      shDnQ    = {2'd3 - offQ, 3'b000};
      byteWord = bus.data_rdata >> shUpQ;
      halfWord = bus.data_rdata >> {offQ[1], 4'b0000};
      case (typeQ)
         3'b100:  loadData = {{24{byteWord[7]}}, byteWord[7:0]};
         3'b000:  loadData = {24'h00_0000, byteWord[7:0]};
         3'b101:  loadData = {{16{halfWord[15]}}, halfWord[15:0]};
         3'b001:  loadData = {16'h0000, halfWord[15:0]};
         3'b011:  loadData = (bus.data_rdata << shDnQ) | (rtQ & ~(32'hFFFF_FFFF << shDnQ));
         3'b111:  loadData = (bus.data_rdata >> shUpQ) | (rtQ & ~(32'hFFFF_FFFF >> shUpQ));
         default: loadData = bus.data_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      issue     = 1'b0;
      capture   = 1'b0;
      setCancel = 1'b0;
      stall     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            stall = startReq;
            if (startReq) begin
               nextState = REQ;
               issue     = 1'b1;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (bus.data_addr_ok) begin
               // A flush racing a same-cycle completion simply discards the result.
               if (bus.data_data_ok) begin
                  nextState = flush ? IDLE : DONE;
                  capture   = !flush;
               end else begin
                  nextState = WAIT;
                  setCancel = flush;
               end
            end else if (flush) begin
               nextState = IDLE;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (bus.data_data_ok) begin
               nextState = (cancelQ || flush) ? IDLE : DONE;
               capture   = !(cancelQ || flush);
            end else begin
               setCancel = flush;
            end
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cancelQ        <= 1'b0;
         isLoadQ        <= 1'b0;
         typeQ          <= 3'b000;
         offQ           <= 2'b00;
         rtQ            <= 32'h0000_0000;
         rdata_out      <= 32'h0000_0000;
         bus.data_req   <= 1'b0;
         bus.data_wr    <= 1'b0;
         bus.data_size  <= 2'd0;
         bus.data_addr  <= '0;
         bus.data_wstrb <= 4'b0000;
         bus.data_wdata <= 32'h0000_0000;
      end else begin
         cancelQ      <= (nextState == WAIT) && (cancelQ || setCancel);
         bus.data_req <= (nextState == REQ);
         if (issue) begin
            isLoadQ        <= mem_read;
            typeQ          <= mem_type;
            offQ           <= addr[1:0];
            rtQ            <= rt_data;
            bus.data_wr    <= mem_write;
            bus.data_size  <= reqSize;
            bus.data_addr  <= reqAddr;
            bus.data_wstrb <= reqStrb;
            bus.data_wdata <= reqData;
         end
         if (capture && isLoadQ) rdata_out <= loadData;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0, mem_write = 1'b0, flush = 1'b0;
   logic [2:0]  mem_type = 3'b110;
   logic [31:0] addr = 32'h0, rt_data = 32'h0;
   logic        stall, done, adel, ades;
   logic [31:0] rdata_out;

   mem_access_unit_if #(.ADDR_W(32)) bus ();

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_type(mem_type), .addr(addr), .rt_data(rt_data), .flush(flush),
      .stall(stall), .done(done), .rdata_out(rdata_out), .adel(adel), .ades(ades),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } busExpType;

   busExpType   busQ[$];
   logic [31:0] rdQ[$];
   int nCompared = 0, nMismatched = 0, doneCount = 0, lat, d0;

   always @(posedge clk) doneCount <= doneCount + (done ? 1 : 0);

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic expectBus(input logic wr, input logic [1:0] size, input logic [31:0] a,
                            input logic [3:0] strb, input logic [31:0] wd);
      busExpType e;
      e.wr = wr; e.size = size; e.addr = a; e.wstrb = strb; e.wdata = wd;
      busQ.push_back(e);
   endtask

   task automatic clearInputs();
      mem_read = 1'b0; mem_write = 1'b0; mem_type = 3'b110; flush = 1'b0;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] ty,
                        input logic [31:0] a, input logic [31:0] rt);
      @(negedge clk);
      mem_read = rd; mem_write = wr; mem_type = ty; addr = a; rt_data = rt;
      #1 checkValue("stall_issue", stall, 1);
   endtask

   // Waits for the bus request and scores it against the oldest expectation.
   task automatic waitReq(output bit seen, output int cyc);
      busExpType e;
      seen = 0; cyc = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk); cyc++;
         seen = bus.data_req;
      end
      if (!seen) begin
         checkValue("req_timeout", 0, 1);
      end else if (busQ.size() == 0) begin
         checkValue("bus_sb_empty", 0, 1);
      end else begin
         e = busQ.pop_front();
         checkValue("bus_wr", bus.data_wr, e.wr);
         checkValue("bus_size", bus.data_size, e.size);
         checkValue("bus_addr", bus.data_addr, e.addr);
         checkValue("bus_wstrb", bus.data_wstrb, e.wstrb);
         if (e.wr) checkValue("bus_wdata", bus.data_wdata, e.wdata);
      end
   endtask

   task automatic runAccess(input logic rd, input logic wr, input logic [2:0] ty,
                            input logic [31:0] a, input logic [31:0] rt,
                            input int aokDly, input int dokDly, input logic [31:0] m,
                            output int latency);
      bit seen; int cyc; bit gotDone;
      logic [31:0] holdAddr;
      drive(rd, wr, ty, a, rt);
      waitReq(seen, cyc);
      latency = -1;
      if (!seen) begin clearInputs(); return; end
      holdAddr = bus.data_addr;
      for (int i = 0; i < aokDly; i++) begin
         @(negedge clk); cyc++;
         checkValue("req_hold", bus.data_req, 1);
         checkValue("addr_hold", bus.data_addr, holdAddr);
         checkValue("stall_req", stall, 1);
      end
      bus.data_addr_ok = 1'b1;
      if (dokDly == 0) begin bus.data_data_ok = 1'b1; bus.data_rdata = m; end
      @(negedge clk); cyc++;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      if (dokDly > 0) begin
         checkValue("req_drop", bus.data_req, 0);
         for (int i = 1; i < dokDly; i++) begin
            @(negedge clk); cyc++;
            checkValue("stall_wait", stall, 1);
         end
         bus.data_data_ok = 1'b1; bus.data_rdata = m;
         @(negedge clk); cyc++;
         bus.data_data_ok = 1'b0;
      end
      gotDone = done;
      for (int i = 0; i < 3 && !gotDone; i++) begin
         @(negedge clk); cyc++;
         gotDone = done;
      end
      checkValue("done_pulse", gotDone, 1);
      if (gotDone) begin
         checkValue("stall_done", stall, 0);
         if (rd) begin
            if (rdQ.size() == 0) checkValue("rd_sb_empty", 0, 1);
            else checkValue("load_data", rdata_out, rdQ.pop_front());
         end
      end
      latency = cyc;
      clearInputs();
      @(negedge clk);
      checkValue("done_once", done, 0);
   endtask

   initial begin
      bit seen; int cyc;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
      #1;
      checkValue("rst_req", bus.data_req, 0);
      checkValue("rst_stall", stall, 0);
      checkValue("rst_done", done, 0);
      checkValue("rst_rdata", rdata_out, 0);
      checkValue("rst_wstrb", bus.data_wstrb, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      expectBus(0, 2'd0, 32'h1003, 4'b0000, 32'h0);
      rdQ.push_back(32'hFFFF_FF80);
      runAccess(1, 0, 3'b100, 32'h1003, 32'h0, 0, 0, 32'h80FF_FFFF, lat);
      checkValue("lb_latency", lat, 2);

      expectBus(0, 2'd0, 32'h1003, 4'b0000, 32'h0);
      rdQ.push_back(32'h0000_0080);
      runAccess(1, 0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF_FFFF, lat);

      expectBus(1, 2'd2, 32'h2000, 4'b0011, 32'h0000_AABB);
      runAccess(0, 1, 3'b011, 32'h2001, 32'hAABB_CCDD, 2, 3, 32'h0, lat);

      expectBus(1, 2'd0, 32'h9002, 4'b0100, 32'hA5A5_A5A5);
      runAccess(0, 1, 3'b000, 32'h9002, 32'h0000_00A5, 1, 0, 32'h0, lat);

      expectBus(0, 2'd1, 32'h8002, 4'b0000, 32'h0);
      rdQ.push_back(32'hFFFF_8001);
      runAccess(1, 0, 3'b101, 32'h8002, 32'h0, 0, 1, 32'h8001_1234, lat);

      expectBus(0, 2'd2, 32'h3000, 4'b0000, 32'h0);
      rdQ.push_back(32'h7788_3344);
      runAccess(1, 0, 3'b011, 32'h3001, 32'h1122_3344, 0, 0, 32'h5566_7788, lat);

      expectBus(0, 2'd2, 32'h3000, 4'b0000, 32'h0);
      rdQ.push_back(32'h1122_5566);
      runAccess(1, 0, 3'b111, 32'h3002, 32'h1122_3344, 1, 2, 32'h5566_7788, lat);

      // Address errors: no request, no stall.
      @(negedge clk);
      mem_read = 1'b1; mem_type = 3'b010; addr = 32'h4002;
      #1;
      checkValue("lw_adel", adel, 1);
      checkValue("lw_ades", ades, 0);
      checkValue("lw_fault_stall", stall, 0);
      seen = 0;
      repeat (3) begin @(negedge clk); seen |= bus.data_req; end
      checkValue("lw_fault_noreq", seen, 0);
      clearInputs();
      @(negedge clk);
      mem_write = 1'b1; mem_type = 3'b001; addr = 32'h4001; rt_data = 32'h1234;
      #1;
      checkValue("sh_ades", ades, 1);
      checkValue("sh_adel", adel, 0);
      checkValue("sh_fault_stall", stall, 0);
      clearInputs();

      // Flush in REQ before addr_ok.
      d0 = doneCount;
      expectBus(0, 2'd2, 32'h6000, 4'b0000, 32'h0);
      drive(1, 0, 3'b010, 32'h6000, 32'h0);
      waitReq(seen, cyc);
      flush = 1'b1;
      @(negedge clk);
      checkValue("flush_req_drop", bus.data_req, 0);
      checkValue("flush_req_stall", stall, 0);
      clearInputs();
      repeat (3) @(negedge clk);
      checkValue("flush_req_nodone", doneCount, d0);

      // Flush in WAIT: data_ok is drained, result discarded.
      expectBus(0, 2'd2, 32'h7000, 4'b0000, 32'h0);
      drive(1, 0, 3'b010, 32'h7000, 32'h0);
      waitReq(seen, cyc);
      bus.data_addr_ok = 1'b1;
      @(negedge clk);
      bus.data_addr_ok = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      clearInputs();
      checkValue("flush_wait_stall", stall, 1);
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.data_data_ok = 1'b0;
      checkValue("flush_wait_done", done, 0);
      checkValue("flush_wait_stall_off", stall, 0);
      checkValue("flush_wait_rdata", rdata_out, 32'h1122_5566);
      repeat (2) @(negedge clk);
      checkValue("flush_wait_nodone", doneCount, d0);

      // Asynchronous reset while in WAIT.
      expectBus(0, 2'd2, 32'h7100, 4'b0000, 32'h0);
      drive(1, 0, 3'b010, 32'h7100, 32'h0);
      waitReq(seen, cyc);
      bus.data_addr_ok = 1'b1;
      @(negedge clk);
      bus.data_addr_ok = 1'b0;
      #2 rst = 1'b1;
      clearInputs();
      #1;
      checkValue("arst_req", bus.data_req, 0);
      checkValue("arst_stall", stall, 0);
      checkValue("arst_addr", bus.data_addr, 0);
      checkValue("arst_size", bus.data_size, 0);
      checkValue("arst_rdata", rdata_out, 0);
      checkValue("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;

      expectBus(1, 2'd2, 32'h5000, 4'b1111, 32'h1234_5678);
      runAccess(0, 1, 3'b010, 32'h5000, 32'h1234_5678, 0, 0, 32'h0, lat);

      checkValue("sb_bus_drained", busQ.size(), 0);
      checkValue("sb_rd_drained", rdQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit for the MIPS pipeline. It consumes the decoder's `MemReadType` encoding together with the read/write strobes, address and rt value. It issues the access on the SRAM-like data-cache bus and returns aligned, extended load data for writeback. The unit holds the pipeline stalled from issue until the bus completes the access, and flags address-error exceptions before any bus traffic.

## Interface
- `ADDR_W`, default 32: address width; data path is fixed at 32 bits.
- `clk`: in, 1. Pipeline clock.
- `rst`: in, 1. Reset, asynchronous and active-high.
- `mem_read`: in, 1. Load in MEM (LB/LBU/LH/LHU/LW/LWL/LWR).
- `mem_write`: in, 1. Store in MEM (SB/SH/SW/SWL/SWR).
- `mem_type`: in, 3. `MemReadType`: 100 LB, 000 LBU/SB, 101 LH, 001 LHU/SH, 010 LW/SW, 011 LWL/SWL, 111 LWR/SWR, 110 idle.
- `addr`: in, ADDR_W. Effective address.
- `rt_data`: in, 32. Store data; merge source for LWL/LWR.
- `flush`: in, 1. Exception flush of the MEM instruction.
- `stall`: out, 1. Freeze the pipeline.
- `done`: out, 1. One-cycle pulse; `rdata_out` is valid and the store has completed.
- `rdata_out`: out, 32. Aligned load result.
- `adel`: out, 1. Load address error.
- `ades`: out, 1. Store address error.
- `data_req`: out, 1. Bus request.
- `data_wr`: out, 1. Bus write.
- `data_size`: out, 2. Access size: 0 byte, 1 half, 2 word.
- `data_addr`: out, ADDR_W. Bus address.
- `data_wstrb`: out, 4. Byte write strobes.
- `data_wdata`: out, 32. Bus write data.
- `data_addr_ok`: in, 1. Request accepted.
- `data_data_ok`: in, 1. Read data valid or write done.
- `data_rdata`: in, 32. Bus read data.

## Operation
- Access valid = `mem_read` XOR `mem_write`, and `mem_type`≠110. Any other combination is no access: no request, no stall.
- Faults are combinational in IDLE only. LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, raise `adel` (load) or `ades` (store). A faulting access issues no bus request and asserts no stall. LWL/LWR/SWL/SWR and byte accesses never fault.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE → REQ when the access is valid, there is no fault and `flush`=0. On this transition, latch type, addr and rt_data and register all bus outputs.
- REQ: `data_req`=1.
  - `flush` with `data_addr_ok`=0 → IDLE, request dropped.
  - `data_addr_ok` with `data_data_ok` in the same cycle → DONE.
  - `data_addr_ok` alone → WAIT.
- WAIT: `data_req`=0. A `flush` in WAIT sets a cancel flag. On `data_data_ok`: cancel set → IDLE with no `done`; cancel clear → DONE.
- Read data is captured into `rdata_out` on the `data_data_ok` cycle.
- DONE: `done`=1 for one cycle, then → IDLE. No new request starts in DONE, because the inputs still belong to the retiring instruction.
- `stall` = (IDLE and access valid and no fault and !`flush`) or REQ or WAIT.
- Bus encoding, with k = `addr[1:0]`:
  - Byte: `data_size`=0, `data_addr`=`addr`.
  - Half: `data_size`=1, `data_addr`=`addr`.
  - Word/LWL/LWR/SWL/SWR: `data_size`=2, `data_addr`={`addr[31:2]`,00}.
- Store strobes and data:
  - SB: wstrb 0001<<k, wdata = byte replicated ×4.
  - SH: wstrb = `addr[1]` ? 1100 : 0011, wdata = half replicated ×2.
  - SW: wstrb 1111, wdata = rt.
  - SWL: wstrb 0001/0011/0111/1111 for k=0..3, wdata = rt>>8(3−k).
  - SWR: wstrb 1111/1110/1100/1000 for k=0..3, wdata = rt<<8k.
- Loads: `data_wr`=0 and `data_wstrb`=0000.
- Load result, with m = `data_rdata`:
  - LB/LBU: byte m>>8k, sign-extended or zero-extended.
  - LH/LHU: half m>>16·`addr[1]`, sign-extended or zero-extended.
  - LW: m.
  - LWL: (m<<8(3−k)) | (rt & low 8(3−k) bits).
  - LWR: (m>>8k) | (rt & high 8k bits).
- `rdata_out` holds its value until the next capture.

## Timing
- Reset (async, any state) → IDLE. All registered outputs go to 0: `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`, `rdata_out`, `done`, cancel flag. `stall`/`adel`/`ades` are 0 unless inputs demand otherwise. An outstanding bus transaction is abandoned; the cache resets with the same signal.
- Minimum latency:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: REQ, with `addr_ok` and `data_ok` both asserted.
  - Cycle 2: DONE, `done`=1, `stall`=0.
- Back-to-back accesses incur one IDLE cycle between them.
- Bus outputs are stable from REQ entry until `addr_ok`. `data_req` drops the cycle after `addr_ok`.
- Flush in IDLE beats a new request. Flush in the same cycle as `addr_ok` in REQ takes WAIT with cancel set.

## Test plan
- LB at addr 0x1003, data_rdata 0x80FF_FFFF, addr_ok and data_ok in the same cycle → `data_size`=0, `rdata_out`=0xFFFF_FF80, `done` in cycle 2.
- SWL at addr 0x2001, rt 0xAABBCCDD, addr_ok after 2 cycles, data_ok 3 cycles later → `data_addr`=0x2000, wstrb 0011, wdata 0x0000AABB, `stall` held until DONE.
- LWR at addr 0x3002, rt 0x11223344, m 0x55667788 → `rdata_out`=0x11225566.
- LW at addr 0x4002 → `adel`=1, `data_req` never 1, `stall`=0. SH at 0x4001 → `ades`=1.
- Flush in REQ before addr_ok → IDLE, no `done`. Flush in WAIT → data_ok drained, no `done`, `rdata_out` unchanged.
- Async reset asserted in WAIT → all outputs 0 immediately. After release, a new SW at 0x5000 with rt 0x12345678 → wstrb 1111, wdata 0x12345678.
